// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: oldest-taken-branch redirect, squash window and stall merge for the fetch PC
module branch_redirect_ctrl #(
  parameter int NUM_LANES     = 4,
  parameter int ADDR_W        = 32,
  parameter int SQUASH_CYCLES = 2,
  parameter int CNT_W         = 16,
  localparam int LW = $clog2(NUM_LANES),
  localparam int SW = $clog2(SQUASH_CYCLES + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_LANES-1:0]        lane_br_valid,
  input  logic [NUM_LANES-1:0]        lane_br_taken,
  input  logic [NUM_LANES*ADDR_W-1:0] lane_br_target,
  input  logic [NUM_LANES-1:0]        lane_stall_req,
  output logic                        pc_branch_taken,
  output logic [ADDR_W-1:0]           pc_new_pc,
  output logic                        pc_stall,
  output logic                        squash,
  output logic [LW-1:0]               redirect_lane,
  output logic [CNT_W-1:0]            redirect_cnt,
  output logic                        misalign_err
);
  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] SQUASH = 1'b1;
  logic [0:0]          state;
  logic [SW-1:0]       sq_cnt;
  logic [NUM_LANES-1:0] hit;
  logic                any_hit;
  logic                redirect;
  logic [LW-1:0]       win;
  logic [ADDR_W-1:0]   win_tgt;
  // lowest-index taken lane wins; descending scan leaves the oldest hit in win
  always_comb begin
    hit = lane_br_valid & lane_br_taken;
    any_hit = |hit;
    win = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) win = hit[i] ? LW'(i) : win;
    win_tgt = lane_br_target[win*ADDR_W +: ADDR_W];
  end
  // PC-facing outputs are combinational; reset and the squash window silence them
  always_comb begin
    redirect = rst && state == RUN && any_hit;
    pc_branch_taken = redirect;
    pc_new_pc = redirect ? {win_tgt[ADDR_W-1:4], 4'h0} : '0;
    pc_stall = rst && state == RUN && !any_hit && |lane_stall_req;
  end
  // redirect bookkeeping and the squash window countdown
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      sq_cnt <= '0;
      squash <= 1'b0;
      redirect_lane <= '0;
      redirect_cnt <= '0;
      misalign_err <= 1'b0;
    end else if (state == SQUASH) begin
      sq_cnt <= sq_cnt - 1'b1;
      if (sq_cnt == SW'(1)) begin
        state <= RUN;
        squash <= 1'b0;
      end
    end else if (any_hit) begin
      state <= SQUASH;
      sq_cnt <= SW'(SQUASH_CYCLES);
      squash <= 1'b1;
      redirect_lane <= win;
      redirect_cnt <= &redirect_cnt ? redirect_cnt : redirect_cnt + 1'b1;
      if (|win_tgt[3:0]) misalign_err <= 1'b1;
    end
  end
endmodule
